// File: rtl/imm_extend_pipe.sv
// Two-stage immediate generator for the SPARC-style decode path: stage 1 classifies
// and extends the immediate field, stage 2 adds it to the PC for PC-relative formats.
module imm_extend_pipe #(
  parameter int OUT_W       = 32,
  parameter int DISP_SHIFT  = 2,
  parameter int SETHI_SHIFT = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [OUT_W-1:0] in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic [OUT_W-1:0] out_target,
  output logic [OUT_W-1:0] out_pc,
  output logic             out_pcrel,
  output logic             out_has_imm,
  output logic [1:0]       out_fmt
);

  function automatic logic [OUT_W-1:0] extend(input logic [31:0] v, input logic sgn);
    logic [OUT_W-1:0] r;
    r       = '0;
    r[31:0] = v;
    for (int b = 32; b < OUT_W; b++) r[b] = sgn & v[31];
    return r;
  endfunction

  logic             adv_p1;
  logic             accept;
  logic             load_p2;

  logic [31:0]      imm32;
  logic             imm_signed;
  logic             pcrel_dec;
  logic             has_dec;
  logic [1:0]       fmt_dec;

  logic             vld_p1_d, vld_p1_q;
  logic [OUT_W-1:0] imm_p1_d, imm_p1_q;
  logic [OUT_W-1:0] pc_p1_d, pc_p1_q;
  logic             pcrel_p1_d, pcrel_p1_q;
  logic             has_p1_d, has_p1_q;
  logic [1:0]       fmt_p1_d, fmt_p1_q;

  logic             vld_p2_d, vld_p2_q;
  logic [OUT_W-1:0] imm_p2_d, imm_p2_q;
  logic [OUT_W-1:0] tgt_p2_d, tgt_p2_q;
  logic [OUT_W-1:0] pc_p2_d, pc_p2_q;
  logic             pcrel_p2_d, pcrel_p2_q;
  logic             has_p2_d, has_p2_q;
  logic [1:0]       fmt_p2_d, fmt_p2_q;

  assign adv_p1   = !vld_p2_q || out_ready;
  assign in_ready = !vld_p1_q || adv_p1;
  assign accept   = in_valid && in_ready;
  assign load_p2  = adv_p1 && vld_p1_q;

  always_comb begin
    imm32      = '0;
    imm_signed = 1'b0;
    pcrel_dec  = 1'b0;
    has_dec    = 1'b0;
    fmt_dec    = 2'b00;
    case (in_instr[31:30])
      2'b01: begin
        imm32      = {{2{in_instr[29]}}, in_instr[29:0]} << DISP_SHIFT;
        imm_signed = 1'b1;
        pcrel_dec  = 1'b1;
        has_dec    = 1'b1;
        fmt_dec    = 2'b01;
      end
      2'b00: begin
        has_dec = 1'b1;
        fmt_dec = 2'b10;
        if (in_instr[24:22] == 3'b100) begin
          imm32 = {10'b0, in_instr[21:0]} << SETHI_SHIFT;
        end else begin
          imm32      = {{10{in_instr[21]}}, in_instr[21:0]} << DISP_SHIFT;
          imm_signed = 1'b1;
          pcrel_dec  = 1'b1;
        end
      end
      default: begin
        if (in_instr[13]) begin
          has_dec = 1'b1;
          fmt_dec = 2'b11;
          // shift counts only exist in the op=10 arithmetic group
          if (in_instr[31:30] == 2'b10 &&
              in_instr[24:19] inside {6'b100101, 6'b100110, 6'b100111}) begin
            imm32 = {27'b0, in_instr[4:0]};
          end else begin
            imm32      = {{19{in_instr[12]}}, in_instr[12:0]};
            imm_signed = 1'b1;
          end
        end
      end
    endcase
  end

  // Stage 1: decoded, extended immediate
  always_comb begin
    vld_p1_d   = vld_p1_q;
    imm_p1_d   = imm_p1_q;
    pc_p1_d    = pc_p1_q;
    pcrel_p1_d = pcrel_p1_q;
    has_p1_d   = has_p1_q;
    fmt_p1_d   = fmt_p1_q;
    if (accept) begin
      vld_p1_d   = 1'b1;
      imm_p1_d   = extend(imm32, imm_signed);
      pc_p1_d    = in_pc;
      pcrel_p1_d = pcrel_dec;
      has_p1_d   = has_dec;
      fmt_p1_d   = fmt_dec;
    end else if (adv_p1) begin
      vld_p1_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1_q <= 1'b0;
    else        vld_p1_q <= vld_p1_d;
  end

  always_ff @(posedge clk) begin
    imm_p1_q   <= imm_p1_d;
    pc_p1_q    <= pc_p1_d;
    pcrel_p1_q <= pcrel_p1_d;
    has_p1_q   <= has_p1_d;
    fmt_p1_q   <= fmt_p1_d;
  end

  // Stage 2: target add, held while the consumer stalls
  always_comb begin
    vld_p2_d   = adv_p1 ? vld_p1_q : vld_p2_q;
    imm_p2_d   = imm_p2_q;
    tgt_p2_d   = tgt_p2_q;
    pc_p2_d    = pc_p2_q;
    pcrel_p2_d = pcrel_p2_q;
    has_p2_d   = has_p2_q;
    fmt_p2_d   = fmt_p2_q;
    if (load_p2) begin
      imm_p2_d   = imm_p1_q;
      tgt_p2_d   = pcrel_p1_q ? pc_p1_q + imm_p1_q : pc_p1_q;
      pc_p2_d    = pc_p1_q;
      pcrel_p2_d = pcrel_p1_q;
      has_p2_d   = has_p1_q;
      fmt_p2_d   = fmt_p1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2_q   <= 1'b0;
      imm_p2_q   <= '0;
      tgt_p2_q   <= '0;
      pc_p2_q    <= '0;
      pcrel_p2_q <= 1'b0;
      has_p2_q   <= 1'b0;
      fmt_p2_q   <= 2'b00;
    end else begin
      vld_p2_q   <= vld_p2_d;
      imm_p2_q   <= imm_p2_d;
      tgt_p2_q   <= tgt_p2_d;
      pc_p2_q    <= pc_p2_d;
      pcrel_p2_q <= pcrel_p2_d;
      has_p2_q   <= has_p2_d;
      fmt_p2_q   <= fmt_p2_d;
    end
  end

  assign out_valid   = vld_p2_q;
  assign out_imm     = imm_p2_q;
  assign out_target  = tgt_p2_q;
  assign out_pc      = pc_p2_q;
  assign out_pcrel   = pcrel_p2_q;
  assign out_has_imm = has_p2_q;
  assign out_fmt     = fmt_p2_q;

endmodule
